// File: rtl/dual_grant_sequencer.sv
// Purpose : takes a 12-bit request batch and issues one grant per handshake, highest bit first.
// Latency : accept at T -> first grant at T+1; one grant per cycle; last handshake at T -> done at T+1.
// Backpressure: grant_ready low holds grant_idx and the pending mask; req_valid is ignored while a batch runs.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_in/req_valid/req_ready      batch input handshake (ready only when idle)
//   grant_idx/grant_valid/grant_ready  grant output handshake; code = bit position + 1, 0 = none
//   busy                     batch in ISSUE
//   done                     one-cycle pulse when a batch completes
//   grant_cnt                (only with GRANT_CNT_EN) grants handed out in the current/last batch
// Optional feature macro: GRANT_CNT_EN
module dual_grant_sequencer #(
  parameter int N_REQ = 12,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic             busy,
`ifdef GRANT_CNT_EN
  output logic [IDX_W-1:0] grant_cnt,
`endif
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic [IDX_W-1:0]   second_q, second_d;
  logic               grant_hs;

  // Code (position + 1) of the highest set bit, 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] top_code(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) c = IDX_W'(i + 1);
    end
    return c;
  endfunction

  // One-hot mask of the bit named by a code; code 0 yields an empty mask.
  function automatic logic [N_REQ-1:0] code_mask(input logic [IDX_W-1:0] code);
    logic [N_REQ-1:0] m;
    for (int i = 0; i < N_REQ; i++) begin
      m[i] = (code == IDX_W'(i + 1));
    end
    return m;
  endfunction

  assign grant_hs = (state_q == S_ISSUE) && grant_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = (req_in == '0) ? S_DONE : S_ISSUE;
      // second_q == 0 means the bit being granted now is the last one left.
      S_ISSUE: if (grant_hs && (second_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q == S_ISSUE);
    grant_valid = (state_q == S_ISSUE);
    grant_idx   = (state_q == S_ISSUE) ? first_q : '0;
    done        = (state_q == S_DONE);
  end

  // Pending mask and the registered first/second pair. On a handshake the
  // already-registered second code becomes the next grant, so consecutive
  // grants need no extra priority-encode cycle; second is then refilled
  // from what remains.
  always_comb begin
    pending_d = pending_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) pending_d = req_in;
      S_ISSUE: if (grant_hs)  pending_d = pending_q & ~code_mask(first_q);
      default: pending_d = pending_q;
    endcase
    first_d  = grant_hs ? second_q : top_code(pending_d);
    second_d = top_code(pending_d & ~code_mask(first_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      first_q   <= '0;
      second_q  <= '0;
    end else begin
      pending_q <= pending_d;
      first_q   <= first_d;
      second_q  <= second_d;
    end
  end

`ifdef GRANT_CNT_EN
  logic [IDX_W-1:0] cnt_q;

  // Cleared on accept, counts handshakes, holds through DONE/IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            cnt_q <= '0;
    else if ((state_q == S_IDLE) && req_valid) cnt_q <= '0;
    else if (grant_hs)                       cnt_q <= cnt_q + IDX_W'(1);
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
